// File: rtl/spi_master.sv
// spi_master: clock-synchronous SPI master for the SPI slave + single-port RAM
// subsystem. A host request {cmd, data} is serialized onto MOSI as a 10-bit
// frame under SS_n. Read-data frames (cmd 11) then collect one RAM byte from
// MISO and return it on rd_data. Every output is registered.
//
// Optional feature: define SPI_MASTER_SEQ_CHECK_EN to reject read frames that
// break the read-addr / read-data alternation the slave expects. Rejected
// requests pulse err and start no frame. Without the macro, err is always 0.
//
// Parameters:
//   RD_WAIT  cycles between the last MOSI bit and the first MISO sample (1..15)
//   GAP      minimum SS_n-high cycles between frames (1..7)
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, cmd, data request strobe, 2-bit command, 8-bit payload
//   busy             frame in progress (c0 through the last gap cycle)
//   done             one-cycle pulse in the first SS_n-high cycle after a frame
//   rd_data          last RAM word received, rd_valid pulses with done on cmd 11
//   err              one-cycle sequencing-error pulse
//   SS_n, MOSI, MISO SPI pins
module spi_master #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CMD, S_SHIFT, S_WAIT, S_RECV, S_GAP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] word_q, word_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_valid_q, rd_valid_d;
  logic       err_q, err_d;

  // A request can be taken while idle or on the edge that ends the final gap
  // cycle, which lets back-to-back frames run with exactly GAP high cycles.
  logic slot, req_bad, accept;

  assign slot   = (state_q == S_IDLE) || (state_q == S_GAP && cnt_q == GAP_LAST);
  assign accept = slot & start & ~req_bad;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  // Set while a read-addr has been sent and its read-data is still owed.
  logic rd_pend_q, rd_pend_d;

  assign req_bad = (cmd == 2'b11 && !rd_pend_q) || (cmd == 2'b10 && rd_pend_q);

  always_comb begin
    rd_pend_d = rd_pend_q;
    if (accept && cmd[1]) rd_pend_d = ~cmd[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_pend_q <= 1'b0;
    else        rd_pend_q <= rd_pend_d;
  end
`else
  assign req_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = slot & start & req_bad;

    case (state_q)
      S_IDLE: ;
      S_SEL:  state_d = S_CMD;
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd0;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d = 4'd0;
          if (word_q[9:8] == 2'b11) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RECV;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECV: begin
        rx_d = {rx_q[5:0], MISO};
        if (cnt_q == 4'd7) begin
          state_d    = S_GAP;
          cnt_d      = 4'd0;
          rd_data_d  = {rx_q, MISO};
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_SEL;
      cnt_d   = 4'd0;
      word_d  = {cmd, data};
    end

    // Pin values are derived from the next state so they appear registered
    // in the same cycle as that state.
    ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_CMD:   mosi_d = word_d[9];
      S_SHIFT: mosi_d = word_d[4'd9 - cnt_d];
      default: mosi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      word_q     <= 10'd0;
      rx_q       <= 7'd0;
      rd_data_q  <= 8'h00;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule
